// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
// Default byte width plus the IDLE/LOCKED state type.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest requester index at or
// after ptr wins, wrapping from N-1 back to 0. Output is one-hot or zero.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   w_dist;
    int   w_best;
    int   w_sel;
    logic w_found;

    always_comb begin
        w_dist  = 0;
        w_best  = N;
        w_sel   = 0;
        w_found = 1'b0;
        // Distance from the pointer, walking upward with wrap.
        for (int i = 0; i < N; i++) begin
            w_dist = (i - int'(ptr) + N) % N;
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = i;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = w_found && (w_sel == i);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Funnels N byte-stream requesters into one UART transmitter, holding a
// grant for a whole message (or MAXLEN bytes) before re-arbitrating.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = BYTE_W,
    parameter int MAXLEN = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   s_valid,
    input  logic [N*W-1:0] s_data,
    input  logic [N-1:0]   s_last,
    output logic [N-1:0]   s_ready,
    output logic           m_valid,
    output logic [W-1:0]   m_data,
    input  logic           m_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(MAXLEN);

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_pick;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_nptr;
    logic [W-1:0]    w_data;
    logic            w_live;
    logic            w_last;
    logic            w_xfer;
    logic            w_end;
    logic [CW:0]     w_cnt_inc;

    rr_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .req (s_valid),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

    // Reset wins over a pending transfer in the same cycle.
    assign w_live = (r_state == ST_LOCKED) && !rst;

    always_comb begin
        w_gidx = '0;
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_gidx = PW'(i);
                w_data = s_data[i*W +: W];
            end
        end
    end

    assign w_nptr    = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
    assign w_last    = |(s_last & r_grant);
    assign w_xfer    = m_valid && m_ready;
    assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);
    assign w_end     = w_last || ((MAXLEN > 0) && (w_cnt_inc == LIMIT));

    assign m_valid = w_live && |(s_valid & r_grant);
    assign m_data  = m_valid ? w_data : '0;
    assign s_ready = (w_live && m_ready) ? r_grant : '0;
    assign grant   = r_grant;
    assign busy    = (r_state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|s_valid) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        if (w_end) begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_cnt   <= '0;
                            r_ptr   <= w_nptr;
                        end else begin
                            r_cnt <= w_cnt_inc[CW-1:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (unlimited and MAXLEN=2)
// share stimulus and are checked each cycle against a message-level model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_valid = '0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_last = '0;
    logic        m_ready = 1'b0;

    logic [3:0]  sr [2];
    logic        mv [2];
    logic [7:0]  md [2];
    logic [3:0]  gr [2];
    logic        bz [2];

    int checks = 0;
    int fails = 0;
    int sel = 0;
    bit rnd = 1'b1;
    bit chk_on = 1'b0;

    logic [8:0]  sq [4][$];
    logic [15:0] xq0 [$];
    logic [15:0] xq1 [$];

    int own [2] = '{-1, -1};
    int mptr [2] = '{0, 0};
    int mcnt [2] = '{0, 0};
    int ml [2] = '{0, 2};

    logic       e_mv;
    logic [7:0] e_md;
    logic [3:0] e_sr;
    logic [3:0] e_gr;
    logic       e_bz;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(4), .W(8), .MAXLEN(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(sr[0]), .m_valid(mv[0]),
        .m_data(md[0]), .m_ready(m_ready), .grant(gr[0]), .busy(bz[0])
    );

    uart_tx_arbiter #(.N(4), .W(8), .MAXLEN(2)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(sr[1]), .m_valid(mv[1]),
        .m_data(md[1]), .m_ready(m_ready), .grant(gr[1]), .busy(bz[1])
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Message-level reference: owner index (-1 when idle), pointer, count.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || own[k] < 0) begin
                e_mv = 1'b0;
                e_md = '0;
                e_sr = '0;
            end else begin
                e_mv = s_valid[own[k]];
                e_md = e_mv ? s_data[own[k]*8 +: 8] : 8'h00;
                e_sr = m_ready ? 4'(1 << own[k]) : 4'h0;
            end
            e_gr = (own[k] < 0) ? 4'h0 : 4'(1 << own[k]);
            e_bz = (own[k] >= 0);
            if (chk_on) begin
                chk($sformatf("m_valid%0d", k), 32'(mv[k]), 32'(e_mv));
                chk($sformatf("m_data%0d", k), 32'(md[k]), 32'(e_md));
                chk($sformatf("s_ready%0d", k), 32'(sr[k]), 32'(e_sr));
                chk($sformatf("grant%0d", k), 32'(gr[k]), 32'(e_gr));
                chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(e_bz));
            end
            if (mv[k] === 1'b1 && m_ready) begin
                if (k == 0) xq0.push_back({4'h0, gr[k], md[k]});
                else        xq1.push_back({4'h0, gr[k], md[k]});
            end
            if (rst) begin
                own[k] = -1;
                mptr[k] = 0;
                mcnt[k] = 0;
            end else if (own[k] < 0) begin
                for (int d = 0; d < 4; d++)
                    if (own[k] < 0 && s_valid[(mptr[k] + d) % 4])
                        own[k] = (mptr[k] + d) % 4;
            end else if (e_mv && m_ready) begin
                mcnt[k]++;
                if (s_last[own[k]] || (ml[k] > 0 && mcnt[k] == ml[k])) begin
                    mptr[k] = (own[k] + 1) % 4;
                    own[k] = -1;
                    mcnt[k] = 0;
                end
            end
        end
    end

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            if (sq[i].size() > 0) begin
                s_valid[i] = 1'b1;
                s_data[i*8 +: 8] = sq[i][0][7:0];
                s_last[i] = sq[i][0][8];
            end else begin
                s_valid[i] = 1'b0;
                s_data[i*8 +: 8] = 8'h00;
                s_last[i] = 1'b0;
            end
        end
    endfunction

    function automatic bit all_empty();
        return sq[0].size() == 0 && sq[1].size() == 0 &&
               sq[2].size() == 0 && sq[3].size() == 0;
    endfunction

    task automatic push(int i, logic [7:0] d, logic l);
        sq[i].push_back({l, d});
        drive();
    endtask

    task automatic tick();
        logic [3:0] pop;
        @(negedge clk);
        pop = sr[sel] & s_valid;
        @(posedge clk);
        #1;
        if (!rnd) begin
            for (int i = 0; i < 4; i++)
                if (pop[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sq[i].delete();
        drive();
        repeat (2) tick();
        rst = 1'b0;
        xq0.delete();
        xq1.delete();
    endtask

    task automatic run_idle(string nm, int max);
        int n;
        n = 0;
        while (n < max && !(all_empty() && !bz[sel])) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, 32'(n < max), 32'd1);
    endtask

    task automatic chk_xq(string nm, int k, logic [15:0] e [$]);
        logic [15:0] q [$];
        if (k == 0) q = xq0;
        else        q = xq1;
        chk({nm, "_len"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 32'(q[i]), 32'(e[i]));
    endtask

    initial begin
        logic [15:0] e [$];

        rst = 1'b1;
        s_valid = 4'hF;
        s_data = 32'hDEADBEEF;
        s_last = 4'hF;
        m_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_grant", 32'(gr[0]), 0);
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_mvalid", 32'(mv[0]), 0);
        chk("rst_mdata", 32'(md[0]), 0);
        chk("rst_sready", 32'(sr[0]), 0);
        rnd = 1'b0;

        // Single message, transmitter ready once every 868 cycles.
        do_reset();
        sel = 0;
        m_ready = 1'b0;
        push(2, 8'h41, 1'b0);
        push(2, 8'h42, 1'b0);
        push(2, 8'h43, 1'b1);
        for (int c = 0; c < 4000 && xq0.size() < 3; c++) begin
            m_ready = (c % 868 == 867);
            tick();
        end
        chk("single_busy_after_last", 32'(bz[0]), 0);
        m_ready = 1'b0;
        e = '{16'h0441, 16'h0442, 16'h0443};
        chk_xq("single_seq", 0, e);

        // All four requesting at reset release.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(i, 8'(8'hA0 + i), 1'b1);
        push(0, 8'hA4, 1'b1);
        run_idle("contend", 100);
        e = '{16'h01A0, 16'h02A1, 16'h04A2, 16'h08A3, 16'h01A4};
        chk_xq("contend_order", 0, e);
        chk_xq("contend_order_m2", 1, e);

        // Owner pauses mid-message while another requester waits.
        do_reset();
        m_ready = 1'b1;
        push(1, 8'h10, 1'b0);
        push(3, 8'h30, 1'b1);
        for (int c = 0; c < 20 && sq[1].size() > 0; c++) tick();
        repeat (20) begin
            tick();
            chk("hold_grant", 32'(gr[0]), 32'h2);
            chk("hold_sready3", 32'(sr[0][3]), 0);
            chk("hold_mvalid", 32'(mv[0]), 0);
        end
        push(1, 8'h11, 1'b1);
        run_idle("hold", 100);
        e = '{16'h0210, 16'h0211, 16'h0830};
        chk_xq("hold_seq", 0, e);

        // MAXLEN=2 splits a stream with no last marker.
        do_reset();
        sel = 1;
        m_ready = 1'b1;
        for (int v = 1; v <= 5; v++) push(0, 8'(v), 1'b0);
        push(1, 8'h21, 1'b0);
        push(1, 8'h22, 1'b1);
        for (int c = 0; c < 100 && !all_empty(); c++) tick();
        repeat (3) tick();
        e = '{16'h0101, 16'h0102, 16'h0221, 16'h0222,
              16'h0103, 16'h0104, 16'h0105};
        chk_xq("maxlen_seq", 1, e);
        chk("maxlen_still_locked", 32'(bz[1]), 1);
        sel = 0;

        // Reset in the middle of a four-byte message.
        do_reset();
        m_ready = 1'b1;
        push(2, 8'h50, 1'b1);
        run_idle("rstmid_pre", 50);
        for (int v = 1; v <= 4; v++) push(2, 8'(8'h50 + v), v == 4);
        for (int c = 0; c < 50 && sq[2].size() > 2; c++) tick();
        rst = 1'b1;
        push(1, 8'h61, 1'b1);
        push(3, 8'h63, 1'b1);
        tick();
        chk("rstmid_grant", 32'(gr[0]), 0);
        chk("rstmid_mvalid", 32'(mv[0]), 0);
        chk("rstmid_busy", 32'(bz[0]), 0);
        chk("rstmid_no_xfer", xq0.size(), 3);
        rst = 1'b0;
        xq0.delete();
        run_idle("rstmid_post", 100);
        e = '{16'h0261, 16'h0453, 16'h0454, 16'h0863};
        chk_xq("rstmid_seq", 0, e);

        // Transmitter stalled for 100 cycles.
        do_reset();
        m_ready = 1'b0;
        push(0, 8'h77, 1'b1);
        push(0, 8'h78, 1'b1);
        repeat (2) tick();
        repeat (100) begin
            tick();
            chk("bp_mvalid", 32'(mv[0]), 1);
            chk("bp_mdata", 32'(md[0]), 32'h77);
            chk("bp_sready", 32'(sr[0]), 0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (2) tick();
        e = '{16'h0177};
        chk_xq("bp_one_xfer", 0, e);
        chk("bp_next_byte", 32'(md[0]), 32'h78);

        // Unconstrained random traffic against the model.
        rnd = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            s_valid = 4'($urandom);
            s_data = $urandom;
            s_last = 4'($urandom) & 4'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, byte width.
REQ-003 Parameter MAXLEN, default 0, max bytes per grant; 0 = unlimited.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  N  per-requester byte valid.
REQ-007 s_data  input  N*W  per-requester byte; requester i occupies bits [i*W +: W].
REQ-008 s_last  input  N  marks a requester's final byte of a message.
REQ-009 s_ready  output  N  per-requester accept strobe.
REQ-010 m_valid  output  1  byte valid to the UART transmitter.
REQ-011 m_data  output  W  byte to the UART transmitter.
REQ-012 m_ready  input  1  transmitter idle; a transfer occurs on a cycle with m_valid && m_ready.
REQ-013 grant  output  N  one-hot owner; all zero when idle.
REQ-014 busy  output  1  high while in LOCKED.

Function
REQ-015 States: IDLE and LOCKED.
REQ-016 IDLE: when s_valid != 0, the block selects a requester round-robin, starting at the index after the last owner, registers it in grant, and enters LOCKED next cycle.
REQ-017 IDLE outputs: m_valid=0 and s_ready=0; arbitration costs exactly 1 cycle.
REQ-018 LOCKED: m_valid = s_valid[g], m_data = s_data[g] (combinational pass-through), and s_ready[g] = m_ready.
REQ-019 LOCKED: s_ready of every non-granted requester is 0.
REQ-020 The bytes-sent counter increments on each transfer.
REQ-021 LOCKED -> IDLE on a transfer with s_last[g]=1.
REQ-022 When MAXLEN>0, LOCKED -> IDLE on the transfer that brings the count to MAXLEN, regardless of s_last.
REQ-023 On leaving LOCKED: grant clears, the counter clears, and the round-robin pointer = g+1 mod N.
REQ-024 The owner may drop s_valid mid-message; the block holds the grant and emits nothing until the owner resumes.
REQ-025 Requests arriving while LOCKED wait; they are not lost and are not reordered relative to the round-robin pointer.
REQ-026 When several requesters are valid in IDLE, the lowest index at or after the pointer wins, wrapping N-1 -> 0.
REQ-027 m_data shall be 0 when m_valid=0.
REQ-028 Back-to-back messages have a 1-cycle IDLE gap minimum.

Reset
REQ-029 rst=1 forces: IDLE, grant=0, busy=0, m_valid=0, m_data=0, s_ready=0, counter=0, pointer=0.
REQ-030 Reset mid-message abandons the message without completing a transfer in the reset cycle; no byte is emitted after rst rises.
REQ-031 After rst falls, the first arbitration follows REQ-016 with pointer=0.

Structure
REQ-032 Shared package uart_pkg holds the byte width constant (8) and the state encodings IDLE=0, LOCKED=1.
REQ-033 Sub-module rr_arbiter (inputs req[N], ptr; output one-hot gnt) performs the combinational round-robin pick.
REQ-034 The counter is $clog2(MAXLEN+1) bits wide, minimum 1.
REQ-035 Target size is 150-300 lines total.

Verification
REQ-036 Single message: s_valid[2] held with bytes 0x41,0x42,0x43, s_last on 0x43, m_ready pulsing every 868 cycles -> m_data sequence 41,42,43; grant=0b0100 throughout; busy falls the cycle after the 0x43 transfer.
REQ-037 Contention: s_valid=0b1111 at reset release, each message 1 byte with last -> grant order 0,1,2,3,0; each grant separated by ≥1 IDLE cycle.
REQ-038 Lock hold: requester 1 sends 0x10 (no last), then s_valid[1]=0 for 20 cycles while s_valid[3]=1 -> grant stays 0b0010, s_ready[3]=0, m_valid=0; 0x11 with last then completes; requester 3 is granted next.
REQ-039 MAXLEN=2 with requester 0 streaming 0x01..0x05 and never asserting last, requester 1 waiting -> grant alternates 0,1,0 after every 2 bytes from requester 0.
REQ-040 Reset mid-message: rst asserted for 1 cycle after the 2nd of 4 bytes -> next cycle grant=0, m_valid=0; post-reset arbitration restarts at index 0.
REQ-041 Backpressure: m_ready=0 for 100 cycles with owner valid -> m_valid=1, m_data stable, s_ready[g]=0; exactly one transfer when m_ready rises.
